// File: rtl/sd_slot_arbiter_if.sv
// Bus bundle between the SD slot arbiter, its three slot requesters and the SD host.
// The master modport is the arbiter side; slave is the requester/host environment.
interface sd_slot_arbiter_if;
    logic [2:0]        req_rd;
    logic [2:0]        req_wr;
    logic [2:0][31:0]  req_lba;
    logic [2:0][7:0]   slot_din;
    logic              sd_ack;
    logic              sd_buff_wr;
    logic              sd_rd;
    logic              sd_wr;
    logic [31:0]       sd_lba;
    logic [7:0]        sd_buff_din;
    logic [2:0]        slot_ack;
    logic [2:0]        slot_buff_wr;
    logic [2:0]        done;
    logic [2:0]        err;
    logic              busy;
    logic              cpu_wait;

    modport master (
        input  req_rd, req_wr, req_lba, slot_din, sd_ack, sd_buff_wr,
        output sd_rd, sd_wr, sd_lba, sd_buff_din, slot_ack, slot_buff_wr,
               done, err, busy, cpu_wait
    );

    modport slave (
        output req_rd, req_wr, req_lba, slot_din, sd_ack, sd_buff_wr,
        input  sd_rd, sd_wr, sd_lba, sd_buff_din, slot_ack, slot_buff_wr,
               done, err, busy, cpu_wait
    );
endinterface

// File: rtl/sd_slot_arbiter.sv
// Round-robin arbiter sharing one SD host port between HDD and two floppy slots,
// with write-before-read per slot and a request timeout while waiting for ack.
module sd_slot_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd14318181
) (
    input  logic              clk,
    input  logic              reset_n,
    sd_slot_arbiter_if.master bus
);
    localparam int unsigned NSLOT = 3;
    localparam int unsigned CNT_W = 24;
    localparam int unsigned LBA_W = 32;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

    state_t             state, state_nx;
    logic [1:0]         grant, grant_nx, last, last_nx, pick, cand;
    logic               pick_vld;
    logic               op_wr, op_wr_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               ack_s, ack_q, ack_q_nx;
    logic               sd_rd_q, sd_rd_nx, sd_wr_q, sd_wr_nx;
    logic               busy_q, busy_nx, cpu_wait_q, cpu_wait_nx;
    logic [LBA_W-1:0]   lba_q, lba_nx;
    logic [NSLOT-1:0]   pending, done_q, done_nx, err_q, err_nx;

    assign pending = bus.req_rd | bus.req_wr;

    // Round-robin search starting one past the last served slot
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = last;
        for (int k = 0; k < int'(NSLOT); k++) begin
            cand = (cand == 2'(NSLOT - 1)) ? 2'd0 : 2'(cand + 2'd1);
            if (!pick_vld && pending[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic; ack edges use the synchronised copy
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        last_nx  = last;
        op_wr_nx = op_wr;
        cnt_nx   = cnt;
        ack_q_nx = ack_s;
        lba_nx   = lba_q;
        sd_rd_nx = 1'b0;
        sd_wr_nx = 1'b0;
        done_nx  = '0;
        err_nx   = '0;

        unique case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_nx = S_REQ;
                    grant_nx = pick;
                    op_wr_nx = bus.req_wr[pick];
                    lba_nx   = bus.req_lba[pick];
                    cnt_nx   = '0;
                    // An ack already high at entry must be seen low before it counts as a rise
                    ack_q_nx = 1'b1;
                    sd_wr_nx = bus.req_wr[pick];
                    sd_rd_nx = !bus.req_wr[pick];
                end
            end
            S_REQ: begin
                if (ack_s && !ack_q) begin
                    state_nx = S_XFER;
                end else if (cnt == TIMEOUT - 24'd1) begin
                    state_nx = S_IDLE;
                    err_nx   = NSLOT'(1) << grant;
                    last_nx  = grant;
                end else begin
                    cnt_nx   = cnt + CNT_W'(1);
                    sd_rd_nx = !op_wr;
                    sd_wr_nx = op_wr;
                end
            end
            S_XFER: begin
                if (!ack_s && ack_q) begin
                    state_nx = S_DONE;
                    done_nx  = NSLOT'(1) << grant;
                    last_nx  = grant;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                grant_nx = '0;
            end
            default: state_nx = S_IDLE;
        endcase

        busy_nx     = (state_nx != S_IDLE);
        cpu_wait_nx = (state_nx != S_IDLE) && (grant_nx == 2'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            grant      <= '0;
            last       <= 2'd2;
            op_wr      <= 1'b0;
            cnt        <= '0;
            ack_s      <= 1'b0;
            ack_q      <= 1'b0;
            lba_q      <= '0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            done_q     <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            cpu_wait_q <= 1'b0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last       <= last_nx;
            op_wr      <= op_wr_nx;
            cnt        <= cnt_nx;
            ack_s      <= bus.sd_ack;
            ack_q      <= ack_q_nx;
            lba_q      <= lba_nx;
            sd_rd_q    <= sd_rd_nx;
            sd_wr_q    <= sd_wr_nx;
            done_q     <= done_nx;
            err_q      <= err_nx;
            busy_q     <= busy_nx;
            cpu_wait_q <= cpu_wait_nx;
        end
    end

    // Host ack, buffer strobe and slot data steered to the granted slot only
    always_comb begin
        bus.slot_ack     = '0;
        bus.slot_buff_wr = '0;
        bus.sd_buff_din  = '0;
        if (state != S_IDLE) begin
            bus.slot_ack[grant]     = bus.sd_ack;
            bus.slot_buff_wr[grant] = bus.sd_ack & bus.sd_buff_wr;
            bus.sd_buff_din         = bus.slot_din[grant];
        end
    end

    assign bus.sd_rd    = sd_rd_q;
    assign bus.sd_wr    = sd_wr_q;
    assign bus.sd_lba   = lba_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
    assign bus.cpu_wait = cpu_wait_q;
endmodule
